ysyx_25020047_exu_seq: RTL



---
 rtl/ysyx_25020047_exu_seq_if.sv | 41 ++++
 rtl/ysyx_25020047_exu_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_exu_seq_if.sv
// ----------------------------------------------------------------------------
// ysyx_25020047_exu_seq_if
// Handshake bundle between register-read/decode (master) and the sequential
// execute unit (slave).
//   Request  : in_valid, in_ready, op[3:0], pc, rdata1, rdata2, imm[11:0]
//   Response : out_valid, out_ready, result, reg_wen, pc_wen, next_pc,
//              halt, illegal
// Parameter XLEN sets the datapath width of pc/rdata/result/next_pc.
// ----------------------------------------------------------------------------
interface ysyx_25020047_exu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [11:0]     imm;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            reg_wen;
    logic            pc_wen;
    logic [XLEN-1:0] next_pc;
    logic            halt;
    logic            illegal;

    // Upstream/downstream side: drives ops in and accepts results.
    modport master (
        output in_valid, op, pc, rdata1, rdata2, imm, out_ready,
        input  in_ready, out_valid, result, reg_wen, pc_wen, next_pc, halt, illegal
    );

    // Execute unit side.
    modport slave (
        input  in_valid, op, pc, rdata1, rdata2, imm, out_ready,
        output in_ready, out_valid, result, reg_wen, pc_wen, next_pc, halt, illegal
    );
endinterface

// File: rtl/ysyx_25020047_exu_seq.sv
// ----------------------------------------------------------------------------
// ysyx_25020047_exu_seq
// Sequential execute unit: one decoded op in per handshake, one result out per
// handshake. Single-cycle ops (ADDI, JALR, EBREAK, illegal) go straight to
// DONE; shifts iterate one bit per cycle; MUL is a fixed XLEN-step shift-add.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of ysyx_25020047_exu_seq_if (valid/ready in,
//                valid/ready out, result/reg_wen/pc_wen/next_pc/halt/illegal)
// Parameters: XLEN datapath width, SHW shift-amount width.
// ----------------------------------------------------------------------------
module ysyx_25020047_exu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_25020047_exu_seq_if.slave bus
);

    localparam logic [3:0] OP_ADDI   = 4'd0;
    localparam logic [3:0] OP_JALR   = 4'd1;
    localparam logic [3:0] OP_EBREAK = 4'd2;
    localparam logic [3:0] OP_SLLI   = 4'd3;
    localparam logic [3:0] OP_SRLI   = 4'd4;
    localparam logic [3:0] OP_SRAI   = 4'd5;
    localparam logic [3:0] OP_MUL    = 4'd6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]      state;
    logic [3:0]      op_q;
    logic [SHW:0]    cnt_q;      // one extra bit so MUL can load XLEN
    logic [XLEN-1:0] opa_q;      // shift operand / multiplicand
    logic [XLEN-1:0] opb_q;      // multiplier, consumed LSB first
    logic [XLEN-1:0] acc_q;      // MUL partial product
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] next_pc_q;
    logic            reg_wen_q;
    logic            pc_wen_q;
    logic            illegal_q;
    logic            halt_q;

    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] opa_step;
    logic [XLEN-1:0] opb_step;
    logic [XLEN-1:0] acc_step;
    logic [SHW:0]    load_cnt;
    logic [XLEN-1:0] direct_res;
    logic [XLEN-1:0] direct_npc;
    logic            direct_wen;
    logic            direct_pcw;
    logic            direct_ill;
    logic            accept;

    // Sign-extending cast also covers XLEN narrower than the 12-bit immediate.
    assign simm   = XLEN'(signed'(bus.imm));
    assign accept = (state == S_IDLE) && bus.in_valid;

    // Step count and single-cycle results, decoded straight from the request.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        load_cnt   = '0;
        direct_res = '0;
        direct_npc = '0;
        direct_wen = 1'b0;
        direct_pcw = 1'b0;
        direct_ill = 1'b0;
        case (bus.op)
            OP_ADDI: begin
                direct_res = bus.rdata1 + simm;
                direct_wen = 1'b1;
            end
            OP_JALR: begin
                direct_res = bus.pc + XLEN'(4);
                direct_npc = (bus.rdata1 + simm) & ~XLEN'(1);
                direct_wen = 1'b1;
                direct_pcw = 1'b1;
            end
            OP_EBREAK: ;
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                // A zero shift finishes immediately with rdata1 unchanged.
                load_cnt   = {1'b0, bus.imm[SHW-1:0]};
                direct_res = bus.rdata1;
                direct_wen = 1'b1;
            end
            OP_MUL: begin
                load_cnt   = (SHW+1)'(XLEN);
                direct_wen = 1'b1;
            end
            default: direct_ill = 1'b1;
        endcase
    end

    // One iteration of the multi-cycle ops.
    always_comb begin
        opa_step = opa_q;
        opb_step = opb_q >> 1;
        acc_step = acc_q;
        case (op_q)
            OP_SLLI: opa_step = opa_q << 1;
            OP_SRLI: opa_step = opa_q >> 1;
            OP_SRAI: opa_step = {opa_q[XLEN-1], opa_q[XLEN-1:1]};
            OP_MUL: begin
                acc_step = opb_q[0] ? acc_q + opa_q : acc_q;
                opa_step = opa_q << 1;
            end
            default: ;
        endcase
    end

    // Control state and the visible result registers.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            next_pc_q <= '0;
            reg_wen_q <= 1'b0;
            pc_wen_q  <= 1'b0;
            illegal_q <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q      <= bus.op;
                        cnt_q     <= load_cnt;
                        result_q  <= direct_res;
                        next_pc_q <= direct_npc;
                        reg_wen_q <= direct_wen;
                        pc_wen_q  <= direct_pcw;
                        illegal_q <= direct_ill;
                        if (load_cnt == '0) begin
                            state <= S_DONE;
                            if (bus.op == OP_EBREAK) halt_q <= 1'b1;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - (SHW+1)'(1);
                    if (cnt_q == (SHW+1)'(1)) begin
                        state    <= S_DONE;
                        result_q <= (op_q == OP_MUL) ? acc_step : opa_step;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready)
                        state <= (op_q == OP_EBREAK) ? S_HALTED : S_IDLE;
                end
                S_HALTED: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: working datapath registers carry no reset; every op reloads them
    // on accept and nothing observes them outside BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_q <= bus.rdata1;
            opb_q <= bus.rdata2;
            acc_q <= '0;
        end else if (state == S_BUSY) begin
            opa_q <= opa_step;
            opb_q <= opb_step;
            acc_q <= acc_step;
        end
    end

    // Handshake flags decode the registered state only.
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.next_pc   = next_pc_q;
    assign bus.reg_wen   = reg_wen_q & bus.out_valid;
    assign bus.pc_wen    = pc_wen_q  & bus.out_valid;
    assign bus.illegal   = illegal_q & bus.out_valid;
    assign bus.halt      = halt_q;

endmodule
